// File: rtl/alu_arbiter.sv
// Round-robin front end that time-shares one external combinational ALU
// between NUM_REQ requesters and returns tagged results on one response channel.

module alu_arbiter_lane (
  input  logic [2:0]  opcode_i,
  input  logic [7:0]  op1_i,
  input  logic [7:0]  op2_i,
  output logic [18:0] req_o
);
  assign req_o = {opcode_i, op1_i, op2_i};
endmodule

module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [3*NUM_REQ-1:0] req_opcode,
  input  logic [8*NUM_REQ-1:0] req_op1,
  input  logic [8*NUM_REQ-1:0] req_op2,
  output logic [2:0]           alu_opcode,
  output logic [7:0]           alu_operand1,
  output logic [7:0]           alu_operand2,
  input  logic [7:0]           alu_result,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_result,
  output logic                 busy
);

  typedef struct packed {
    logic [2:0] opcode;
    logic [7:0] op1;
    logic [7:0] op2;
  } alu_req_t;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                  state_q, state_d;
  alu_req_t [NUM_REQ-1:0]  lane_req;
  logic [ID_W-1:0]         rr_ptr_q, gnt_idx;
  logic                    gnt_vld, accept;
  logic [2:0]              alu_opcode_q;
  logic [7:0]              alu_op1_q, alu_op2_q, rsp_result_q;
  logic                    rsp_valid_q, busy_q;
  logic [ID_W-1:0]         rsp_id_q;
  logic [ID_W:0]           scan;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    alu_arbiter_lane u_lane (
      .opcode_i (req_opcode[3*i +: 3]),
      .op1_i    (req_op1[8*i +: 8]),
      .op2_i    (req_op2[8*i +: 8]),
      .req_o    (lane_req[i])
    );
  end

  // First valid requester at or after rr_ptr, wrapping past NUM_REQ-1.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (scan >= (ID_W+1)'(NUM_REQ)) scan = scan - (ID_W+1)'(NUM_REQ);
      if (!gnt_vld && req_valid[scan[ID_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan[ID_W-1:0];
      end
    end
  end

  assign accept = (state_q == IDLE) && gnt_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      alu_opcode_q <= '0;
      alu_op1_q    <= '0;
      alu_op2_q    <= '0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      busy_q <= (state_d != IDLE);
      if (accept) begin
        alu_opcode_q <= lane_req[gnt_idx].opcode;
        alu_op1_q    <= lane_req[gnt_idx].op1;
        alu_op2_q    <= lane_req[gnt_idx].op2;
        rsp_id_q     <= gnt_idx;
        rr_ptr_q     <= (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
      end
      if (state_q == EXEC) begin
        rsp_result_q <= alu_result;
        rsp_valid_q  <= 1'b1;
      end
      if (state_q == RESP && rsp_ready) rsp_valid_q <= 1'b0;
    end
  end

  assign alu_opcode   = alu_opcode_q;
  assign alu_operand1 = alu_op1_q;
  assign alu_operand2 = alu_op2_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: acts as the external ALU and checks every cycle
// against a transaction-level model of grant order, latency and response data.

module tb_alu_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [3*N-1:0] req_opcode = '0;
  logic [8*N-1:0] req_op1 = '0, req_op2 = '0;
  logic [2:0]     alu_opcode;
  logic [7:0]     alu_operand1, alu_operand2, alu_result;
  logic           rsp_valid, rsp_ready = 1'b0;
  logic [IW-1:0]  rsp_id;
  logic [7:0]     rsp_result;
  logic           busy;

  always #5 clk = ~clk;

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return ~a;
      3'd3:    return a & b;
      3'd4:    return a | b;
      3'd5:    return a ^ b;
      3'd6:    return {a[6:0], 1'b0};
      default: return {1'b0, a[7:1]};
    endcase
  endfunction

  assign alu_result = alu_f(alu_opcode, alu_operand1, alu_operand2);

  alu_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_op1(req_op1), .req_op2(req_op2),
    .alu_opcode(alu_opcode), .alu_operand1(alu_operand1), .alu_operand2(alu_operand2),
    .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .busy(busy)
  );

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Transaction model: one operation outstanding at most; response visible
  // one edge after accept; next grant only once the response has drained.
  int         m_rr = 0;
  bit         m_inflight = 0, m_visible = 0;
  int         m_id = 0;
  logic [7:0] m_res = '0;
  int         cyc = 0;
  int         dut_gnt[$], dut_cyc[$];
  logic [N-1:0] acc_mask;

  task automatic put(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_valid[i]        = 1'b1;
    req_opcode[3*i +: 3] = op;
    req_op1[8*i +: 8]    = a;
    req_op2[8*i +: 8]    = b;
  endtask

  // Called just after a falling edge with inputs driven; returns at the next falling edge.
  task automatic step();
    int g;
    logic [N-1:0] exp_rdy;
    #1;
    g = -1;
    if (!m_inflight)
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(m_rr + k) % N]) g = (m_rr + k) % N;
    exp_rdy = (g >= 0) ? N'(1) << g : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("busy", 32'(busy), 32'(m_inflight));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_visible));
    if (m_visible) begin
      chk("rsp_id", 32'(rsp_id), 32'(m_id));
      chk("rsp_result", 32'(rsp_result), 32'(m_res));
    end
    for (int i = 0; i < N; i++)
      if (req_ready[i]) begin dut_gnt.push_back(i); dut_cyc.push_back(cyc); end
    acc_mask = req_valid & req_ready;
    if (m_inflight && m_visible && rsp_ready) begin
      m_inflight = 0; m_visible = 0;
    end else if (m_inflight && !m_visible) begin
      m_visible = 1;
    end else if (!m_inflight && g >= 0) begin
      m_inflight = 1;
      m_id  = g;
      m_res = alu_f(req_opcode[3*g +: 3], req_op1[8*g +: 8], req_op2[8*g +: 8]);
      m_rr  = (g + 1) % N;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    m_rr = 0; m_inflight = 0; m_visible = 0;
    chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_outs", {rsp_id, rsp_result, alu_opcode, alu_operand1, alu_operand2, busy}, 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (4) step();
  endtask

  initial begin
    int base;
    @(negedge clk);
    do_reset();

    // Single add on port 0
    rsp_ready = 1'b1;
    put(0, 3'd0, 8'h05, 8'h03);
    step();
    chk("add_grant", 32'(dut_gnt[$]), 0);
    req_valid = '0;
    step();
    chk("add_rsp_valid", 32'(rsp_valid), 1);
    chk("add_rsp_id", 32'(rsp_id), 0);
    chk("add_rsp_result", 32'(rsp_result), 32'h08);
    drain();

    // Sub wrap and shr1 on port 2
    put(2, 3'd1, 8'h00, 8'h01);
    step(); req_valid = '0; step();
    chk("sub_wrap", 32'(rsp_result), 32'hFF);
    chk("sub_id", 32'(rsp_id), 2);
    drain();
    put(2, 3'd7, 8'h81, 8'h00);
    step(); req_valid = '0; step();
    chk("shr1", 32'(rsp_result), 32'h40);
    drain();

    // Round robin from a fresh pointer, all ports always valid
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) put(i, 3'($urandom), 8'($urandom), 8'($urandom));
    base = dut_gnt.size();
    repeat (13) step();
    chk("rr_count", 32'(dut_gnt.size() - base), 5);
    for (int i = 0; i < 5 && base + i < dut_gnt.size(); i++) begin
      chk("rr_order", 32'(dut_gnt[base + i]), 32'(i % N));
      if (i > 0) chk("rr_spacing", 32'(dut_cyc[base + i] - dut_cyc[base + i - 1]), 3);
    end
    drain();

    // Backpressure: response held 5 cycles while port 1 waits
    put(0, 3'd5, 8'hA5, 8'h0F);
    rsp_ready = 1'b0;
    step();
    req_valid = '0;
    put(1, 3'd3, 8'hF0, 8'h3C);
    step();
    repeat (5) step();
    rsp_ready = 1'b1;
    step();
    step();
    chk("bp_grant", 32'(dut_gnt[$]), 1);
    chk("bp_delay", 32'(dut_cyc[$] - dut_cyc[$-1]), 8);
    req_valid = '0;
    drain();

    // Pointer wrap: rr_ptr=1 with only port 0 valid
    do_reset();
    put(0, 3'd4, 8'h11, 8'h22);
    step(); req_valid = '0; drain();
    put(0, 3'd2, 8'h33, 8'h00);
    step();
    chk("wrap_grant", 32'(dut_gnt[$]), 0);
    req_valid = '0; drain();
    put(0, 3'd0, 8'h01, 8'h01);
    put(1, 3'd0, 8'h02, 8'h02);
    step();
    chk("wrap_ptr", 32'(dut_gnt[$]), 1);
    req_valid[1] = 1'b0;
    drain();

    // Reset during EXEC discards the operation
    put(2, 3'd0, 8'h10, 8'h20);
    step();
    req_valid = '0;
    do_reset();
    step();
    put(3, 3'd6, 8'hC3, 8'h00);
    step(); req_valid = '0; step();
    chk("post_rst_id", 32'(rsp_id), 3);
    chk("post_rst_res", 32'(rsp_result), 32'h86);
    drain();

    // Random traffic under the requester hold rule
    repeat (600) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(0, 2) == 0)
          put(i, 3'($urandom), 8'($urandom), 8'($urandom));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
      req_valid = req_valid & ~acc_mask;
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d", total);
    $fatal(1);
  end
endmodule
